fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC register, the next-PC selection and the IF/ID pipeline register.
- It supplies the decode-stage instruction and PC to the decode-stage branch comparator and register-file read logic.
- It consumes the comparator's branch-taken result and the forwarded rs value to resolve branches and jumps in D.
- Branch and jump instructions have one architectural delay slot. No squash is ever performed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset. It is also the pc_d value after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  from the hazard unit; when 1, holds the PC and the IF/ID register.
- imem_addr  out  32  fetch address; equals pc_f.
- imem_rdata  in  32  instruction at imem_addr; combinational read, valid in the same cycle.
- cmp_true  in  1  decode-stage comparator result for the instruction in ir_d (1 = branch condition met).
- rs_val_d  in  32  forwarded GPR[rs] for the instruction in ir_d; used by jr/jalr.
- ir_d  out  32  instruction currently in the decode stage (IF/ID.IR).
- pc_d  out  32  PC of ir_d.
- pc8_d  out  32  pc_d + 8; link value for jal/jalr.
- pc_f  out  32  current fetch PC.

Behaviour:
- Reset: clock and reset are fixed as above. Asserting reset clears state immediately, independent of clk, and overrides stall and all other inputs. Reset values:
  - pc_f = RESET_PC.
  - ir_d = 32'h0000_0000 (nop).
  - pc_d = RESET_PC.
  - pc8_d = RESET_PC + 8.
- Reset deasserted mid-operation: fetch restarts at RESET_PC on the first rising edge.
- Outputs:
  - ir_d and pc_d are registered.
  - pc8_d = pc_d + 8, combinational from the register.
  - imem_addr = pc_f.
- Normal cycle (stall = 0), on each rising edge:
  - pc_f <= npc.
  - ir_d <= imem_rdata.
  - pc_d <= pc_f.
- Stall cycle (stall = 1): pc_f, ir_d and pc_d all hold. npc is ignored, even if ir_d is a taken branch; the redirect is re-evaluated on the first unstalled cycle from the same held ir_d.
- npc selection is decoded from ir_d only (op = ir_d[31:26], rt = ir_d[20:16], funct = ir_d[5:0]), with pc4d = pc_d + 4. Priority order:
  1. Branch taken: op is 000100 beq, 000101 bne, 000110 blez or 000111 bgtz, or op is 000001 with rt 00000 (bltz) or 00001 (bgez); and cmp_true = 1. Then npc = pc4d + (sign_extend(ir_d[15:0]) << 2).
  2. j / jal (op 000010 or 000011): npc = {pc4d[31:28], ir_d[25:0], 2'b00}.
  3. jr / jalr (op 000000 and funct 001000 or 001001): npc = rs_val_d.
  4. Otherwise: npc = pc_f + 4.
- Ignored cases:
  - Regimm (op 000001) with any other rt is not a branch, and cmp_true is ignored.
  - A branch with cmp_true = 0 falls to case 4.
- Delay slot: when the redirect is taken, the instruction already at pc_f (the delay slot) enters D normally. Nothing is flushed.
- Arithmetic:
  - All adds are 32-bit modulo 2^32. Wrap-around is silent (e.g. pc_f = 32'hFFFF_FFFC gives npc 32'h0000_0000).
  - Negative branch offsets sign-extend to 32 bits before the shift.
- Alignment: no alignment check. jr to a misaligned address is loaded into pc_f unchanged.
- cmp_true and rs_val_d are sampled only in the cycle they are used; their values while stalled are don't-care.

Decomposition:
- Shared package (mips_pkg) holds:
  - opcode constants: OP_RTYPE, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ.
  - funct constants: FN_JR, FN_JALR.
  - regimm rt constants: RT_BLTZ, RT_BGEZ.
  - the RESET_PC default.
  - the comparator uses the same constants.
- One combinational sub-module, npc_sel: inputs ir_d, pc_d, pc_f, cmp_true, rs_val_d; output npc. fetch_stage holds only the registers and the stall muxing.

Test Plan:
- Reset: assert reset mid-cycle with pc_f = 32'h0000_3010 -> immediately pc_f = 32'h0000_3000, ir_d = 0, pc_d = 32'h0000_3000; after release, sequential fetch 3000, 3004, 3008.
- Taken beq: beq at 32'h3008 with imm = 16'hFFFE, cmp_true = 1 -> delay slot at 32'h300C enters D; next fetch is 32'h3004. Repeat with cmp_true = 0 -> next fetch is 32'h3010.
- Jumps: jal with index 26'h0000C10 at pc_d = 32'h3000 -> npc = 32'h0000_3040, pc8_d = 32'h3008. jr with rs_val_d = 32'h0000_3100 -> npc = 32'h3100.
- Stall on branch: stall = 1 for 2 cycles while a bgtz sits in D, with cmp_true toggling -> pc_f, ir_d and pc_d constant; on release with cmp_true = 1, redirect to the target.
- Non-branch regimm: op 000001, rt = 00010, cmp_true = 1 -> npc = pc_f + 4.
- Wrap-around: pc_f = 32'hFFFF_FFFC, no redirect -> pc_f becomes 32'h0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants used by the fetch stage and the decode-stage comparator.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_JALR   = 6'b001001;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  // Word offset of a branch: sign-extend first, then scale to bytes.
  function automatic logic [XLEN-1:0] branch_offset(input logic [15:0] imm);
    return {{(XLEN-18){imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory port plus the IF/ID outputs and decode-stage feedback.
interface fetch_stage_if;
  import mips_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            cmp_true;
  logic [XLEN-1:0] rs_val_d;
  logic [XLEN-1:0] ir_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc8_d;
  logic [XLEN-1:0] pc_f;

  modport master (
    output imem_addr, ir_d, pc_d, pc8_d, pc_f,
    input  imem_rdata, cmp_true, rs_val_d
  );

  modport slave (
    input  imem_addr, ir_d, pc_d, pc8_d, pc_f,
    output imem_rdata, cmp_true, rs_val_d
  );

endinterface

// File: rtl/fetch_stage_npc_sel.sv
// Next-PC selection, decoded purely from the instruction sitting in D.
module npc_sel
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] ir_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_f,
  input  logic            cmp_true,
  input  logic [XLEN-1:0] rs_val_d,
  output logic [XLEN-1:0] npc
);

  logic [5:0]      op;
  logic [4:0]      rt;
  logic [5:0]      funct;
  logic [XLEN-1:0] pc4d;
  logic            is_branch;
  logic            is_jump;
  logic            is_jreg;

  assign op    = ir_d[31:26];
  assign rt    = ir_d[20:16];
  assign funct = ir_d[5:0];
  assign pc4d  = pc_d + XLEN'(4);

  // Regimm only counts as a branch for bltz/bgez; other rt values fall through.
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
                     ((op == OP_REGIMM) && ((rt == RT_BLTZ) || (rt == RT_BGEZ)));
  assign is_jump   = (op == OP_J) || (op == OP_JAL);
  assign is_jreg   = (op == OP_RTYPE) && ((funct == FN_JR) || (funct == FN_JALR));

  always_comb begin
    npc = pc_f + XLEN'(4);
    if (is_branch && cmp_true) begin
      npc = pc4d + branch_offset(ir_d[15:0]);
    end else if (is_jump) begin
      npc = {pc4d[31:28], ir_d[25:0], 2'b00};
    end else if (is_jreg) begin
      npc = rs_val_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register and stall hold; redirects resolve in D
// with one delay slot and no squash.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] ir_d_q, ir_d_d;
  logic [XLEN-1:0] pc_d_q, pc_d_d;
  logic [XLEN-1:0] npc;

  npc_sel u_npc_sel (
    .ir_d     (ir_d_q),
    .pc_d     (pc_d_q),
    .pc_f     (pc_f_q),
    .cmp_true (bus.cmp_true),
    .rs_val_d (bus.rs_val_d),
    .npc      (npc)
  );

  // A stall freezes everything; a pending redirect is simply recomputed once released.
  always_comb begin
    pc_f_d = pc_f_q;
    ir_d_d = ir_d_q;
    pc_d_d = pc_d_q;
    if (!stall) begin
      pc_f_d = npc;
      ir_d_d = bus.imem_rdata;
      pc_d_d = pc_f_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q <= RESET_PC;
      ir_d_q <= '0;
      pc_d_q <= RESET_PC;
    end else begin
      pc_f_q <= pc_f_d;
      ir_d_q <= ir_d_d;
      pc_d_q <= pc_d_d;
    end
  end

  assign bus.imem_addr = pc_f_q;
  assign bus.pc_f      = pc_f_q;
  assign bus.ir_d      = ir_d_q;
  assign bus.pc_d      = pc_d_q;
  assign bus.pc8_d     = pc_d_q + XLEN'(8);

endmodule
